operand_fetch_unit: RTL

- Front-end stage of the 6502 core. It fetches the opcode byte at PC and presents it to the addressing-mode decoder.
- Using the decoded addressing mode, it fetches 0–2 operand bytes and any indirect pointer bytes, then computes the effective address.
- It hands one fully resolved instruction at a time to execute over a valid/ready handshake.
- Single outstanding memory read; owns the PC.

---
 rtl/nes_pkg.sv | 24 ++
 rtl/ea_calc.sv | 37 +++
 rtl/operand_fetch_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// Shared definitions for the 6502 front end: widths, addressing modes,
// fetch-state encoding and the resolved-instruction record handed to execute.
package nes_pkg;

    localparam int BYTE   = 8;
    localparam int ADDR_W = 16;

    typedef enum logic [3:0] {
        IMP, ACC, IMM, ZP, ZPX, ZPY, ABS, ABX, ABY, IND, IZX, IZY, REL
    } addressing_mode_t;

    typedef enum logic [2:0] {
        FETCH_OP, WAIT_OP, FETCH_LO, FETCH_HI, FETCH_PTR_LO, FETCH_PTR_HI, ISSUE
    } fetch_state_t;

    typedef struct packed {
        logic [BYTE-1:0]   opcode;
        addressing_mode_t  mode;
        logic [ADDR_W-1:0] operand;
        logic [ADDR_W-1:0] ea;
        logic [ADDR_W-1:0] pc_next;
    } instr_t;

endpackage

// File: rtl/ea_calc.sv
// Effective-address calculator: purely combinational, one result per
// addressing mode from the operand bytes, pointer bytes and index registers.
module ea_calc
    import nes_pkg::*;
(
    input  addressing_mode_t  mode_i,
    input  logic [BYTE-1:0]   lo_i,
    input  logic [BYTE-1:0]   hi_i,
    input  logic [BYTE-1:0]   p_lo_i,
    input  logic [BYTE-1:0]   p_hi_i,
    input  logic [BYTE-1:0]   x_i,
    input  logic [BYTE-1:0]   y_i,
    input  logic [ADDR_W-1:0] pc_next_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic [ADDR_W-1:0] ea_o
);

    // Mode-dependent address arithmetic; zero-page forms wrap inside page 0
    always_comb begin
        ea_o = '0;
        case (mode_i)
            IMM:     ea_o = fetch_addr_i;
            ZP:      ea_o = {8'h00, lo_i};
            ZPX:     ea_o = {8'h00, lo_i + x_i};
            ZPY:     ea_o = {8'h00, lo_i + y_i};
            ABS:     ea_o = {hi_i, lo_i};
            ABX:     ea_o = {hi_i, lo_i} + {8'h00, x_i};
            ABY:     ea_o = {hi_i, lo_i} + {8'h00, y_i};
            REL:     ea_o = pc_next_i + {{8{lo_i[7]}}, lo_i};
            IZX:     ea_o = {p_hi_i, p_lo_i};
            IZY:     ea_o = {p_hi_i, p_lo_i} + {8'h00, y_i};
            IND:     ea_o = {p_hi_i, p_lo_i};
            default: ea_o = '0;
        endcase
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// 6502 operand fetch unit: fetches opcode, operand and pointer bytes with a
// single outstanding read, resolves the effective address and hands one
// instruction at a time to execute over valid/ready.
// Optional build macro JMP_IND_WRAP_BUG_EN: when defined, the IND pointer
// high-byte read wraps within the pointer's page (NMOS page bug).
module operand_fetch_unit
    import nes_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'hC000
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_rvalid_i,
    input  logic [BYTE-1:0]   mem_rdata_i,
    output logic [BYTE-1:0]   opcode_o,
    input  addressing_mode_t  addressing_mode_i,
    input  logic [BYTE-1:0]   x_i,
    input  logic [BYTE-1:0]   y_i,
    input  logic              pc_load_i,
    input  logic [ADDR_W-1:0] pc_load_val_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [BYTE-1:0]   instr_opcode_o,
    output addressing_mode_t  instr_mode_o,
    output logic [ADDR_W-1:0] instr_operand_o,
    output logic [ADDR_W-1:0] instr_ea_o,
    output logic [ADDR_W-1:0] instr_pc_next_o
);

    fetch_state_t      state_q;
    addressing_mode_t  mode_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] ea_w;
    logic [ADDR_W-1:0] ind_hi_addr;
    logic [BYTE-1:0]   opcode_q;
    logic [BYTE-1:0]   lo_q, hi_q, p_lo_q, p_hi_q;
    logic [BYTE-1:0]   lo_d, hi_d, p_lo_d, p_hi_d;
    logic              req_q, valid_q, outst_q, drop_q;
    logic              rx;
    instr_t            instr_q, instr_d;

    // Accepted read data and the byte/PC values as they stand after this cycle
    always_comb begin
        rx     = mem_rvalid_i && outst_q && !drop_q;
        lo_d   = lo_q;
        hi_d   = hi_q;
        p_lo_d = p_lo_q;
        p_hi_d = p_hi_q;
        pc_d   = pc_q;
        if (rx) begin
            case (state_q)
                FETCH_OP:     pc_d = pc_q + 16'd1;
                FETCH_LO: begin
                    lo_d = mem_rdata_i;
                    pc_d = pc_q + 16'd1;
                end
                FETCH_HI: begin
                    hi_d = mem_rdata_i;
                    pc_d = pc_q + 16'd1;
                end
                FETCH_PTR_LO: p_lo_d = mem_rdata_i;
                FETCH_PTR_HI: p_hi_d = mem_rdata_i;
                default: ;
            endcase
        end
    end

    // Second pointer byte address for JMP (ind): the last read address + 1
    always_comb begin
`ifdef JMP_IND_WRAP_BUG_EN
        ind_hi_addr = {addr_q[15:8], addr_q[7:0] + 8'd1};
`else
        ind_hi_addr = addr_q + 16'd1;
`endif
    end

    ea_calc u_ea_calc (
        .mode_i       (mode_q),
        .lo_i         (lo_d),
        .hi_i         (hi_d),
        .p_lo_i       (p_lo_d),
        .p_hi_i       (p_hi_d),
        .x_i          (x_i),
        .y_i          (y_i),
        .pc_next_i    (pc_d),
        .fetch_addr_i (addr_q),
        .ea_o         (ea_w)
    );

    // Resolved record captured on the final byte of the instruction
    always_comb begin
        instr_d = '{opcode: opcode_q, mode: mode_q, operand: {hi_d, lo_d},
                    ea: ea_w, pc_next: pc_d};
    end

    // Fetch sequencer: one request in flight, redirect overrides everything
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= FETCH_OP;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= '0;
            opcode_q <= '0;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            mode_q   <= IMP;
            outst_q  <= 1'b0;
            drop_q   <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            p_lo_q   <= '0;
            p_hi_q   <= '0;
        end else begin
            req_q <= 1'b0;
            if (mem_rvalid_i) begin
                outst_q <= 1'b0;
                drop_q  <= 1'b0;
            end
            if (pc_load_i) begin
                pc_q    <= pc_load_val_i;
                valid_q <= 1'b0;
                state_q <= FETCH_OP;
                outst_q <= 1'b0;
                if (outst_q && !mem_rvalid_i) begin
                    drop_q <= 1'b1;
                end
            end else begin
                pc_q   <= pc_d;
                lo_q   <= lo_d;
                hi_q   <= hi_d;
                p_lo_q <= p_lo_d;
                p_hi_q <= p_hi_d;
                case (state_q)
                    FETCH_OP: begin
                        if (rx) begin
                            opcode_q <= mem_rdata_i;
                            state_q  <= WAIT_OP;
                        end else if (!outst_q && !drop_q) begin
                            req_q   <= 1'b1;
                            addr_q  <= pc_q;
                            outst_q <= 1'b1;
                        end
                    end
                    WAIT_OP: begin
                        mode_q <= addressing_mode_i;
                        lo_q   <= '0;
                        hi_q   <= '0;
                        p_lo_q <= '0;
                        p_hi_q <= '0;
                        if (addressing_mode_i == IMP || addressing_mode_i == ACC) begin
                            instr_q <= '{opcode: opcode_q, mode: addressing_mode_i,
                                         operand: 16'h0000, ea: 16'h0000, pc_next: pc_q};
                            valid_q <= 1'b1;
                            state_q <= ISSUE;
                        end else begin
                            req_q   <= 1'b1;
                            addr_q  <= pc_q;
                            outst_q <= 1'b1;
                            state_q <= FETCH_LO;
                        end
                    end
                    FETCH_LO: begin
                        if (rx) begin
                            case (mode_q)
                                ABS, ABX, ABY, IND: begin
                                    req_q   <= 1'b1;
                                    addr_q  <= pc_d;
                                    outst_q <= 1'b1;
                                    state_q <= FETCH_HI;
                                end
                                IZX: begin
                                    req_q   <= 1'b1;
                                    addr_q  <= {8'h00, mem_rdata_i + x_i};
                                    outst_q <= 1'b1;
                                    state_q <= FETCH_PTR_LO;
                                end
                                IZY: begin
                                    req_q   <= 1'b1;
                                    addr_q  <= {8'h00, mem_rdata_i};
                                    outst_q <= 1'b1;
                                    state_q <= FETCH_PTR_LO;
                                end
                                default: begin
                                    instr_q <= instr_d;
                                    valid_q <= 1'b1;
                                    state_q <= ISSUE;
                                end
                            endcase
                        end
                    end
                    FETCH_HI: begin
                        if (rx) begin
                            if (mode_q == IND) begin
                                req_q   <= 1'b1;
                                addr_q  <= {mem_rdata_i, lo_q};
                                outst_q <= 1'b1;
                                state_q <= FETCH_PTR_LO;
                            end else begin
                                instr_q <= instr_d;
                                valid_q <= 1'b1;
                                state_q <= ISSUE;
                            end
                        end
                    end
                    FETCH_PTR_LO: begin
                        if (rx) begin
                            req_q   <= 1'b1;
                            addr_q  <= (mode_q == IND) ? ind_hi_addr
                                                       : {8'h00, addr_q[7:0] + 8'd1};
                            outst_q <= 1'b1;
                            state_q <= FETCH_PTR_HI;
                        end
                    end
                    FETCH_PTR_HI: begin
                        if (rx) begin
                            instr_q <= instr_d;
                            valid_q <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (instr_ready_i) begin
                            valid_q <= 1'b0;
                            state_q <= FETCH_OP;
                        end
                    end
                    default: state_q <= FETCH_OP;
                endcase
            end
        end
    end

    assign mem_req_o       = req_q;
    assign mem_addr_o      = addr_q;
    assign opcode_o        = opcode_q;
    assign instr_valid_o   = valid_q;
    assign instr_opcode_o  = instr_q.opcode;
    assign instr_mode_o    = instr_q.mode;
    assign instr_operand_o = instr_q.operand;
    assign instr_ea_o      = instr_q.ea;
    assign instr_pc_next_o = instr_q.pc_next;

endmodule
